// File: rtl/lcd_frame_scheduler.sv
// Frame RAM arbiter: render window grants renderer writes, refresh window hands the RAM to the LCD Driver.
// Optional stall counter built only when LCD_SCHED_STALL_CNT_EN is defined.
module lcd_frame_scheduler #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 8,
    parameter int FRAME_CYCLES   = 500000,
    parameter int REFRESH_CYCLES = 200000,
    parameter int START_LEN      = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              drv_start_o,
    input  logic [ADDR_W-1:0] drv_addr_i,
    output logic [DATA_W-1:0] drv_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    output logic              render_ok_o,
    output logic              frame_tick_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [15:0]       stall_cnt_o
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int RS    = FRAME_CYCLES - REFRESH_CYCLES;

    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(FRAME_CYCLES - 2);
    localparam logic [CNT_W-1:0] PRE_START    = CNT_W'(RS - 1);
    localparam logic [CNT_W-1:0] PRE_REFRESH  = CNT_W'(RS + START_LEN - 1);

    typedef enum logic [1:0] {
        ST_RENDER  = 2'd0,
        ST_START   = 2'd1,
        ST_REFRESH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               drv_start_q, drv_start_d;
    logic               frame_tick_q, frame_tick_d;
    logic               grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RENDER;
            frame_cnt_q  <= '0;
            drv_start_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            drv_start_q  <= drv_start_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // State changes are decided one count early so state_q lines up with frame_cnt_q.
    always_comb begin
        frame_cnt_d = (frame_cnt_q == LAST_CNT) ? '0 : frame_cnt_q + 1'b1;
        state_d     = state_q;
        case (state_q)
            ST_RENDER:  if (frame_cnt_q == PRE_START)   state_d = ST_START;
            ST_START:   if (frame_cnt_q == PRE_REFRESH) state_d = ST_REFRESH;
            ST_REFRESH: if (frame_cnt_q == LAST_CNT)    state_d = ST_RENDER;
            default:                                    state_d = ST_RENDER;
        endcase
    end

    always_comb begin
        drv_start_d  = (state_d == ST_START);
        frame_tick_d = (frame_cnt_q == PRE_LAST_CNT);
        grant        = wr_req_i && (state_q == ST_RENDER) && !rst;
        render_ok_o  = (state_q == ST_RENDER);
        drv_start_o  = drv_start_q;
        frame_tick_o = frame_tick_q;
        wr_ack_o     = grant;
        ram_we_o     = grant;
        ram_addr_o   = grant ? wr_addr_i : drv_addr_i;
        ram_wdata_o  = wr_data_i;
        drv_data_o   = ram_rdata_i;
    end

`ifdef LCD_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Cleared on the edge after the frame tick, so the first cycle of a frame reads 0.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (frame_tick_q) begin
            stall_cnt_d = '0;
        end else if (wr_req_i && !grant && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
